// File: rtl/inst_fetch_controller.sv
// Instruction fetch controller: owns the PC, fetches one word per cycle into an in-order queue
// drained by decode over valid/ready. Optional starvation counter enabled by IFETCH_STALL_CNT_EN.
module inst_fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [31:0]      STEP_C   = 32'(PC_STEP);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic             push, pop;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);

  always_comb begin
    pop  = out_valid & out_ready;
    // A full queue still accepts a fetch when the head leaves in the same cycle.
    push = ~rst & ~halt & ~redirect_valid & ((count_q < DEPTH_C) | pop);
  end

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    if (redirect_valid) begin
      // Flush wins over everything, including a handshake decode thinks it made.
      pc_d    = align_pc(redirect_pc);
      count_d = '0;
      rptr_d  = '0;
      wptr_d  = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + STEP_C;
        wptr_d = ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_inc(rptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      count_q <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
    end
  end

  // Queue storage carries no reset; the outputs are masked to zero while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wptr_q] <= imem_inst;
      pc_mem[wptr_q]   <= pc_q;
    end
  end

  always_comb begin
    out_inst = '0;
    out_pc   = '0;
    if (out_valid) begin
      out_inst = inst_mem[rptr_q];
      out_pc   = pc_mem[rptr_q];
    end
  end

`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (~rst & out_ready & ~out_valid & (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_controller.sv
// Scoreboard bench for inst_fetch_controller: a queue-based fetch model predicts delivered
// (pc, inst) pairs; a negedge monitor pops and compares them against the DUT.
module tb_inst_fetch_controller;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam int          STEP     = 4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_addr, imem_inst, out_inst, out_pc;
  logic        out_valid;
`ifdef IFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  assign imem_inst = mem_word(imem_addr);

  inst_fetch_controller #(
    .RESET_PC(RESET_PC),
    .DEPTH   (DEPTH),
    .PC_STEP (STEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .halt          (halt),
    .imem_addr     (imem_addr),
    .imem_inst     (imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc)
`ifdef IFETCH_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  int          n_vec  = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  int          mcount = 0;
  logic [31:0] mpc    = RESET_PC;
  logic [31:0] mstall = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: evaluates the fetch rules at every rising edge.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      mcount = 0;
      mpc    = RESET_PC;
      mstall = '0;
    end else begin
      bit p;
      bit pu;
      if (out_ready && mcount == 0 && mstall != 32'hFFFF_FFFF) mstall = mstall + 1;
      p = (mcount > 0) && out_ready;
      if (redirect_valid) begin
        exp_q.delete();
        mcount = 0;
        mpc    = {redirect_pc[31:2], 2'b00};
      end else begin
        pu = !halt && (mcount < DEPTH || p);
        if (p) mcount--;
        if (pu) begin
          exp_q.push_back({mpc, mem_word(mpc)});
          mcount++;
          mpc = mpc + STEP;
        end
      end
    end
  end

  // Monitor: compares outputs mid-cycle and retires the head on a real handshake.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("imem_addr", imem_addr, mpc);
      chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() > 0) begin
        chk("out_pc", out_pc, exp_q[0][63:32]);
        chk("out_inst", out_inst, exp_q[0][31:0]);
        if (out_ready && !redirect_valid) void'(exp_q.pop_front());
      end else begin
        chk("out_pc_empty", out_pc, 32'h0);
        chk("out_inst_empty", out_inst, 32'h0);
      end
`ifdef IFETCH_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, mstall);
`endif
    end
  end

  task automatic step(input logic h, input logic r, input logic rv, input logic [31:0] rp);
    halt           = h;
    out_ready      = r;
    redirect_valid = rv;
    redirect_pc    = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_steps(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
      step($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rp);
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming with decode always ready.
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    // Backpressure fills the queue, then drains without bubbles.
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    // Redirect with a full queue and an unaligned target.
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0023);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);
    // Halt drains the queue and freezes the PC.
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    // Halt together with a redirect still reloads the PC.
    step(1'b1, 1'b1, 1'b1, 32'h0000_1000);
    repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0);

    rand_steps(1500);

    // Asynchronous reset mid-stream with a full queue.
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
    #1 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'h0);
    chk("async_imem_addr", imem_addr, RESET_PC);
    chk("async_out_pc", out_pc, 32'h0);
`ifdef IFETCH_STALL_CNT_EN
    chk("async_stall_cnt", stall_cnt, 32'h0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    // Starved decode: halted with out_ready high.
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    rand_steps(300);
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_controller.md
Name: inst_fetch_controller

Overview:
Sequences the byte-addressed instruction memory: owns the program counter, drives the memory address each cycle, and captures the returned 32-bit word. Fetched words go into a small in-order queue, which decode drains over a valid/ready handshake. Branch/jump redirects flush the queue and reload the PC. A halt input freezes fetching. Sits between the instruction memory and the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
DEPTH, 2, queue entries; legal values 1..8
PC_STEP, 4, bytes added to the PC per fetched instruction

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
halt  in  1  level; while 1, no new fetches; the queue still drains
imem_addr  out  32  byte address to instruction memory; equals the pc register
imem_inst  in  32  instruction word returned combinationally for imem_addr
redirect_valid  in  1  one-cycle pulse: flush and reload the PC
redirect_pc  in  32  new PC; bits [1:0] are ignored and forced to 0
out_valid  out  1  head queue entry valid
out_ready  in  1  decode accepts the head entry
out_inst  out  32  instruction at the queue head
out_pc  out  32  PC of the instruction at the queue head

Behaviour:
- Reset (asynchronous, any time, including mid-stream):
  - pc = RESET_PC; queue count = 0; read/write pointers = 0.
  - out_valid = 0; out_inst = 0; out_pc = 0.
  - Operation resumes on the first rising edge after rst falls.
- imem_addr = pc, purely from the register. The memory read is combinational; imem_inst is sampled at the same edge.
- pop = out_valid & out_ready.
- push:
  - push = ~rst & ~halt & ~redirect_valid & (count < DEPTH | pop).
  - Pushing while full is allowed only when a pop happens in the same cycle, giving full throughput with a combinational path from out_ready.
- On push: queue[wptr] <= {pc, imem_inst}; wptr advances mod DEPTH; pc <= pc + PC_STEP, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Count update: count changes by push − pop. A simultaneous push and pop leaves count unchanged.
- Redirect (highest priority):
  - count <= 0; both pointers <= 0; pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle. A concurrent pop is discarded, because the entry is flushed anyway; decode must treat its handshake that cycle as void.
  - The next cycle fetches from the new PC, so redirect-to-first-valid latency is 1 cycle.
- Outputs:
  - out_valid = (count != 0).
  - out_inst and out_pc come from queue[rptr]. They are 0 when empty and must stay stable while out_valid=1 and out_ready=0.
- Halt:
  - Asserting halt stops pc advancing on the same edge.
  - Deasserting halt resumes fetching at the held pc with no gap.
  - halt together with redirect: the redirect is still applied (pc reloads, queue flushes).
- Empty pop: not possible; pop is gated by out_valid.
- States (implicit in count): EMPTY (count=0), PARTIAL, FULL (count=DEPTH). Transitions follow push/pop/redirect as above.

Optional Feature:
- Macro IFETCH_STALL_CNT_EN.
- When defined:
  - Adds port stall_cnt, out, 32 bits.
  - Increments on every cycle with out_ready=1 & out_valid=0 & rst=0, meaning decode is starved.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 by rst only, not by redirect.
- When undefined: the port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset with RESET_PC=0, hold out_ready=1, mem[0..7] = two words -> out_valid rises 1 cycle after rst falls. out_pc sequence 0, 4; out_inst equals the stored words; one instruction per cycle.
2. out_ready=0 for 5 cycles from reset -> count saturates at 2, pc holds at 8, out_pc holds 0. Raising out_ready then yields out_pc 0, 4, 8 with no bubble.
3. Queue holding PCs 0 and 4, redirect_valid pulse with redirect_pc=0x0000_0023 -> next cycle out_valid=0. The cycle after, out_pc=0x20; PCs 0 and 4 are never delivered.
4. halt=1 for 3 cycles with out_ready=1 -> the queue drains, out_valid=0, imem_addr constant. Releasing halt resumes at the held pc.
5. redirect_pc=0xFFFF_FFFC, out_ready=1 -> out_pc sequence 0xFFFF_FFFC, 0x0000_0000.
6. rst asserted asynchronously mid-stream with the queue full -> out_valid=0, imem_addr=RESET_PC before the next clock edge. With IFETCH_STALL_CNT_EN: stall_cnt=0 after reset, then counts 1 per starved cycle.
